// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // One-hot vector with only bit s set.
    function automatic logic [N_REQ-1:0] onehot_of(input logic [SEL_W-1:0] s);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first unmasked request at or above ptr,
// wrapping modulo N_REQ.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N_REQ-1:0] masked;
    logic [SEL_W-1:0] pos;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        masked = req & ~mask;
        found  = 1'b0;
        idx    = ptr;
        pos    = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (masked[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the select of an 8:1 data mux.
// Each winner owns the mux for HOLD_CYCLES cycles or until it drops its
// request; a new winner follows on the same edge with no idle cycle.
// Optional feature: define MUX_SCHED_PRIO0_EN to give req[0] absolute
// priority at every arbitration point.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter  int HOLD_CYCLES = 4,
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             valid,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic             DONE_ON_LOAD = (HOLD_CYCLES == 1);

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [N_REQ-1:0] grant_q;
    logic             valid_q;
    logic             done_q;

    logic [SEL_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_mask;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             end_win;

    // In HOLD the picker sees the pointer as it will be after this window,
    // with the current winner masked so others get precedence.
    always_comb begin
        pick_ptr  = ptr_q;
        pick_mask = '0;
        if (state_q == HOLD) begin
            pick_ptr  = sel_q + SEL_W'(1);
            pick_mask = onehot_of(sel_q);
        end
    end

    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Final winner: optional source-0 priority, then round-robin, then the
    // current winner again when it is the only one still asking.
    always_comb begin
        win_idx   = rr_idx;
        win_found = rr_found;
        if (state_q == HOLD && !rr_found && req[sel_q]) begin
            win_idx   = sel_q;
            win_found = 1'b1;
        end
`ifdef MUX_SCHED_PRIO0_EN
        if (req[0]) begin
            win_idx   = '0;
            win_found = 1'b1;
        end
`endif
        end_win = (cnt_q == '0) || !req[sel_q];
    end

    // Scheduler FSM with registered outputs; done is looked ahead one cycle
    // so it lines up with the last valid cycle of a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en && win_found) begin
                        state_q <= HOLD;
                        sel_q   <= win_idx;
                        grant_q <= onehot_of(win_idx);
                        valid_q <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                        if (DONE_ON_LOAD) done_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                        grant_q <= '0;
                    end
                end
                HOLD: begin
                    if (end_win) begin
                        ptr_q <= sel_q + SEL_W'(1);
                        // Early release: done lands one cycle after the drop.
                        if (cnt_q != '0) done_q <= 1'b1;
                        if (en && win_found) begin
                            sel_q   <= win_idx;
                            grant_q <= onehot_of(win_idx);
                            valid_q <= 1'b1;
                            cnt_q   <= CNT_LOAD;
                            if (DONE_ON_LOAD) done_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            grant_q <= '0;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign valid = valid_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed testbench for mux_rr_scheduler (HOLD_CYCLES = 4).
module tb_mux_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       done;

    int checks = 0;
    int errors = 0;

    mux_rr_scheduler #(.HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .sel   (sel),
        .grant (grant),
        .valid (valid),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en    = 1'b0;
        req   = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
        checks++;
        if (grant !== 8'h00) begin errors++; $display("FAIL reset_grant got %h want 00", grant); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    // Sole requester 0 keeps winning; done every 4th valid cycle.
    task automatic test_single();
        do_reset();
        en  = 1'b1;
        req = 8'h01;
        tick();
        for (int v = 1; v <= 12; v++) begin
            checks++;
            if (valid !== 1'b1 || sel !== 3'd0 || grant !== 8'h01) begin
                errors++;
                $display("FAIL single_grant cyc %0d got v=%b s=%0d g=%h want v=1 s=0 g=01", v, valid, sel, grant);
            end
            checks++;
            if (done !== ((v % 4) == 0)) begin
                errors++;
                $display("FAIL single_done cyc %0d got %b want %b", v, done, ((v % 4) == 0));
            end
            tick();
        end
    endtask

    // All requesting: 0..7 then 0, 4 cycles each, no gaps.
    task automatic test_rr_all();
        logic [2:0] es;
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        tick();
        for (int v = 0; v < 36; v++) begin
            es = 3'((v / 4) % 8);
            checks++;
            if (valid !== 1'b1 || sel !== es) begin
                errors++;
                $display("FAIL rr_all_sel cyc %0d got v=%b s=%0d want v=1 s=%0d", v, valid, sel, es);
            end
            checks++;
            if (done !== ((v % 4) == 3)) begin
                errors++;
                $display("FAIL rr_all_done cyc %0d got %b want %b", v, done, ((v % 4) == 3));
            end
            tick();
        end
    endtask

    // Two requesters 2 and 5 alternate, pointer wrapping past 7.
    task automatic test_pair();
        logic [2:0] es;
        logic [7:0] eg;
        do_reset();
        en  = 1'b1;
        req = 8'h24;
        tick();
        for (int v = 0; v < 20; v++) begin
            es = (((v / 4) % 2) == 1) ? 3'd5 : 3'd2;
            eg = (((v / 4) % 2) == 1) ? 8'h20 : 8'h04;
            checks++;
            if (valid !== 1'b1 || sel !== es || grant !== eg) begin
                errors++;
                $display("FAIL pair cyc %0d got v=%b s=%0d g=%h want v=1 s=%0d g=%h", v, valid, sel, grant, es, eg);
            end
            tick();
        end
    endtask

    // Winner 3 drops after 2 valid cycles; done next cycle with winner 4.
    task automatic test_early_release();
        do_reset();
        en  = 1'b1;
        req = 8'h08;
        tick();
        checks++;
        if (valid !== 1'b1 || sel !== 3'd3 || done !== 1'b0) begin
            errors++;
            $display("FAIL early_first got v=%b s=%0d d=%b want v=1 s=3 d=0", valid, sel, done);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || sel !== 3'd3 || done !== 1'b0) begin
            errors++;
            $display("FAIL early_second got v=%b s=%0d d=%b want v=1 s=3 d=0", valid, sel, done);
        end
        req = 8'h10;
        tick();
        checks++;
        if (valid !== 1'b1 || sel !== 3'd4 || grant !== 8'h10 || done !== 1'b1) begin
            errors++;
            $display("FAIL early_handoff got v=%b s=%0d g=%h d=%b want v=1 s=4 g=10 d=1", valid, sel, grant, done);
        end
        tick();
        tick();
        checks++;
        if (sel !== 3'd4 || done !== 1'b0) begin
            errors++;
            $display("FAIL early_mid got s=%0d d=%b want s=4 d=0", sel, done);
        end
        tick();
        checks++;
        if (sel !== 3'd4 || valid !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL early_next_done got s=%0d v=%b d=%b want s=4 v=1 d=1", sel, valid, done);
        end
    endtask

    // en dropped mid-window: window completes, then idle until en returns.
    task automatic test_en_low();
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        tick();
        tick();
        en = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b1 || sel !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL enlow_v3 got v=%b s=%0d d=%b want v=1 s=0 d=0", valid, sel, done);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL enlow_v4 got v=%b d=%b want v=1 d=1", valid, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || grant !== 8'h00 || done !== 1'b0 || sel !== 3'd0) begin
                errors++;
                $display("FAIL enlow_idle %0d got v=%b g=%h d=%b s=%0d want v=0 g=00 d=0 s=0", i, valid, grant, done, sel);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || sel !== 3'd1 || grant !== 8'h02) begin
            errors++;
            $display("FAIL enlow_resume got v=%b s=%0d g=%h want v=1 s=1 g=02", valid, sel, grant);
        end
    endtask

    // Asynchronous reset mid-window; restart from index 0.
    task automatic test_reset_mid();
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (sel !== 3'd1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got s=%0d v=%b want s=1 v=1", sel, valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 3'd0 || grant !== 8'h00 || valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got s=%0d g=%h v=%b d=%b want all 0", sel, grant, valid, done);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_held got v=%b d=%b want 0 0", valid, done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || sel !== 3'd0 || grant !== 8'h01 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_restart got v=%b s=%0d g=%h d=%b want v=1 s=0 g=01 d=0", valid, sel, grant, done);
        end
    endtask

`ifdef MUX_SCHED_PRIO0_EN
    // Source 0 wins every arbitration against source 7.
    task automatic test_prio0();
        do_reset();
        en  = 1'b1;
        req = 8'h81;
        tick();
        for (int v = 0; v < 16; v++) begin
            checks++;
            if (valid !== 1'b1 || sel !== 3'd0) begin
                errors++;
                $display("FAIL prio0 cyc %0d got v=%b s=%0d want v=1 s=0", v, valid, sel);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MUX_SCHED_PRIO0_EN
        test_prio0();
`else
        test_single();
        test_rr_all();
        test_pair();
        test_early_release();
        test_en_low();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler for the 8:1 data multiplexer. It arbitrates eight request lines and drives the mux select index. Each winner holds the mux for a fixed window of cycles; an early release ends the window sooner. The block sits directly in front of the mux select inputs and converts the combinational 8:1 path into a time-shared resource with a fair, registered grant.

## Interface
- HOLD_CYCLES, 4, length of a grant window in clock cycles; legal range 1..256.
- CNT_W, $clog2(HOLD_CYCLES+1), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  reset, asynchronous and active-low; the block uses one clock.
- en  input  1  scheduler enable; when low, no new grant is issued.
- req  input  8  per-source request; req[i] asks for mux input i.
- sel  output  3  binary mux select index; the mux forwards d[sel].
- grant  output  8  one-hot grant; grant[sel] = 1 while valid, all-zero otherwise.
- valid  output  1  sel/grant currently own the mux.
- done  output  1  single-cycle pulse in the last cycle of a grant window.

## Operation
- States: IDLE, HOLD.
- IDLE
  - If en=1 and req≠0, pick the first set req[i] scanning upward from ptr, modulo 8.
  - Register sel=i, grant=1<<i, valid=1, cnt=HOLD_CYCLES-1; go to HOLD.
  - Otherwise stay in IDLE with valid=0.
- HOLD, each cycle:
  - End condition: cnt==0, or req[sel]==0 (early release).
  - If the end condition is false, decrement cnt.
  - On the end condition, assert done for that cycle and load ptr=sel+1 (wraps 7→0).
  - Then, if en=1 and req has any bit set other than the current winner, arbitrate from the new ptr in the same edge and reload HOLD. This gives back-to-back grants with no idle cycle.
  - Otherwise go to IDLE with valid=0 and grant=0.
- Winner re-request: the current winner may win again back-to-back only if it is the sole requester.
- ptr is internal, 3 bits, and changes only at window end.
- en falling during HOLD: the current window runs to completion; no new grant follows.
- req changes for non-winners during HOLD are ignored until the window ends.
- sel holds its last value while valid=0; only grant and valid go to zero.

## Timing
- All outputs are registered. Reset value of sel, grant, valid and done is 0. Internal state after reset: IDLE, ptr=0, cnt=0.
- Grant latency: a request sampled at edge k in IDLE gives valid=1 after edge k, i.e. one cycle.
- Window length is HOLD_CYCLES cycles of valid=1 per grant without early release, and a minimum of 1 cycle.
- done is high in the final valid cycle of the window. It coincides with the last valid=1 cycle, not the following cycle.
- Early release: req[sel] seen low at edge k ends the window at that edge, and done is high in the cycle after edge k.
- Reset assertion mid-window clears all state immediately (asynchronous); no done is emitted.

## Configuration
- MUX_SCHED_PRIO0_EN
  - Defined: req[0] overrides round-robin. At any arbitration point, req[0]=1 wins regardless of ptr. ptr still updates from the actual winner. An active non-zero window is not preempted.
  - Undefined: pure round-robin over all eight sources, with no source favoured.

## Structure
- Package mux_sched_pkg holds:
  - N_REQ=8 and SEL_W=3.
  - The state enum typedef {IDLE, HOLD}.
  - The function onehot_of(sel).
- Sub-module rr_pick: purely combinational. Inputs are req[7:0], ptr[2:0] and a mask of the current winner. Outputs are idx[2:0] and found. It is instantiated once and shared by the IDLE and HOLD arbitration paths.

## Test plan
- Reset, then en=1, req=8'h01 held, HOLD_CYCLES=4 -> valid high 1 cycle after req; sel=0, grant=8'h01; done pulse every 4th valid cycle; valid never drops.
- req=8'hFF constant -> sel sequence 0,1,2,…,7,0 with each value held 4 cycles; no gaps in valid.
- req=8'h24 -> sel alternates 2,5,2,5; grant=8'h04/8'h20; ptr wraps correctly from 5 to 2.
- Winner sel=3, req[3] dropped after 2 valid cycles -> done in the next cycle; next winner granted without an idle cycle; window shortened to 2 or 3 cycles as specified.
- en low mid-window with req=8'hFF -> current window completes with done; then valid=0 and grant=0 until en returns.
- rst_n pulsed low mid-window -> all outputs 0 asynchronously, no done; the first grant after release starts from index 0. With MUX_SCHED_PRIO0_EN defined, req=8'h81 -> sel=0 at every arbitration point.
